// File: rtl/pc_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ctrl -- multi-cycle instruction sequencer that owns the PC control inputs
//
// Walks each instruction through FETCH -> EXEC -> (MEM) -> WB. It handshakes
// with instruction and data memory, strobes the instruction register, gates
// the register-file write and issues exactly one PC update per retired
// instruction. ECALL/EBREAK parks the core in a sticky HALT state.
//
// Optional feature macro: PC_CTRL_TIMEOUT_EN
//   defined   : FETCH/MEM waits are bounded by MEM_TIMEOUT cycles; on expiry
//               the core halts and raises the sticky timeout_err flag.
//   undefined : memory waits are unbounded and timeout_err is tied to 0.
//
// Parameters
//   CNT_W        width of the retired-instruction counter (wraps)
//   MEM_TIMEOUT  maximum ack wait in cycles (timeout build only)
//
// Ports
//   clk          system clock
//   clr          asynchronous active-high reset
//   run          core enable, sampled in IDLE and at the end of WB
//   imem_ack     instruction word available this cycle
//   dmem_ack     data access completes this cycle
//   is_jump      decoded JAL/JALR
//   is_branch    decoded conditional branch
//   branch_cond  ALU comparison result
//   is_mem       decoded load/store
//   halt_instr   decoded ECALL/EBREAK
//   imem_req     instruction fetch request (whole of FETCH)
//   ir_load      latch the instruction register (FETCH with ack)
//   dmem_req     data memory request (whole of MEM)
//   reg_we       register-file write enable (WB, non-branch)
//   pc_inc       PC += 4 strobe
//   pc_load      PC <= jump target strobe
//   pc_branch    PC <= branch target strobe
//   pc_disable   hold the PC (low only in WB)
//   halted       core stopped in HALT
//   timeout_err  sticky memory-timeout flag
//   state        current state code, for debug
//   retire_count number of retired instructions
// ---------------------------------------------------------------------------
module pc_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             is_jump,
    input  logic             is_branch,
    input  logic             branch_cond,
    input  logic             is_mem,
    input  logic             halt_instr,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             reg_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             pc_branch,
    output logic             pc_disable,
    output logic             halted,
    output logic             timeout_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] retire_q;
    logic             timeout_hit;   // a bounded wait expires this cycle

    // A zero timeout would halt before memory could ever answer.
    if (MEM_TIMEOUT == 0) begin : g_mem_timeout_check
        $error("pc_ctrl: MEM_TIMEOUT must be at least 1");
    end

    // -----------------------------------------------------------------------
    // Memory wait timeout
    // -----------------------------------------------------------------------
`ifdef PC_CTRL_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              timeout_q;

    // A cycle spent in FETCH/MEM without the matching ack.
    assign waiting = ((cur_state == S_FETCH) && !imem_ack) ||
                     ((cur_state == S_MEM)   && !dmem_ack);

    // wait_cnt holds the number of earlier unacknowledged cycles, so the
    // MEM_TIMEOUT-th empty cycle is the one that expires. An ack in that
    // cycle keeps waiting low and therefore wins.
    assign timeout_hit = waiting && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    // Any cycle that is not an empty wait clears the counter, so it always
    // starts at zero on entry to FETCH or MEM.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt  <= waiting ? wait_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (run) begin
                    nxt_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    nxt_state = S_EXEC;
                end else if (timeout_hit) begin
                    nxt_state = S_HALT;
                end
            end
            S_EXEC: begin
                // Halt outranks a memory op: no data request is ever issued.
                if (halt_instr) begin
                    nxt_state = S_HALT;
                end else if (is_mem) begin
                    nxt_state = S_MEM;
                end else begin
                    nxt_state = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    nxt_state = S_WB;
                end else if (timeout_hit) begin
                    nxt_state = S_HALT;
                end
            end
            S_WB: begin
                // run dropping mid-instruction only takes effect here.
                nxt_state = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                nxt_state = S_HALT;
            end
            default: begin
                // Unused codes 6 and 7 recover to IDLE.
                nxt_state = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        reg_we     = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_branch  = 1'b0;
        pc_disable = 1'b1;
        halted     = 1'b0;
        case (cur_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_MEM: begin
                dmem_req = 1'b1;
            end
            S_WB: begin
                pc_disable = 1'b0;
                // Exactly one PC strobe, jump > taken branch > increment.
                if (is_jump) begin
                    pc_load = 1'b1;
                end else if (is_branch && branch_cond) begin
                    pc_branch = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
                // Branches have no destination register.
                reg_we = !is_branch;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Retired-instruction counter: one count per WB cycle, wraps naturally.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            retire_q <= '0;
        end else if (cur_state == S_WB) begin
            retire_q <= retire_q + 1'b1;
        end
    end

    assign state        = cur_state;
    assign retire_count = retire_q;

endmodule
